pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Sequencing controller for the 5-stage pipeline; it sits beside the forwarding logic, which resolves bypass selects. It decides per cycle whether PC and IF/ID advance, whether ID/EX receives a bubble, and whether wrong-path instructions are flushed. It covers post-reset fill, load-use stalls, taken-branch flush and flag-dependency stalls, and keeps saturating stall/flush performance counters.

## Interface
- FILL_CYCLES, 4: cycles after reset release with PC frozen and the pipe flushed (1..15).
- FLUSH_CYCLES, 1: cycles `ifid_flush` stays asserted per taken branch (1..3).
- clk  in  1  pipeline clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_rn, id_rm, id_rd  in  5 each  register fields of the instruction in ID.
- id_uses_rm  in  1  ID instruction reads Rm (ADDS/SUBS).
- id_uses_rd  in  1  ID instruction reads Rd as a source (MOVK, CBZ).
- id_is_bcond  in  1  ID instruction is B.cond.
- ex_mem_read  in  1  EX instruction is LDUR/LDURB.
- ex_rd  in  5  destination of the EX instruction.
- ex_set_flags  in  1  EX instruction sets NZCV.
- br_taken_ex  in  1  branch resolved taken in EX this cycle.
- cnt_clr  in  1  synchronous clear of both counters.
- pc_we  out  1  PC write enable.
- ifid_we  out  1  IF/ID register write enable.
- ifid_flush  out  1  IF/ID loads a NOP.
- idex_bubble  out  1  ID/EX loads a NOP (control zeroed).
- flag_fwd  out  1  select EX flags for B.cond evaluation (only with macro).
- stall_cnt, flush_cnt  out  16 each  saturating event counters.

## Operation
- States: FILL, RUN, LOAD_STALL, FLAG_WAIT, FLUSH. Outputs are Mealy: state plus current inputs.
- FILL: pc_we=0, ifid_we=0, ifid_flush=1, idex_bubble=1. A 4-bit down-counter loads FILL_CYCLES on reset. FILL → RUN when the counter reaches 0.
- RUN defaults: pc_we=1, ifid_we=1, ifid_flush=0, idex_bubble=0, flag_fwd=0.
- Load-use hazard: ex_mem_read & ex_rd≠31 & (ex_rd==id_rn | (id_uses_rm & ex_rd==id_rm) | (id_uses_rd & ex_rd==id_rd)).
  - In the same cycle: pc_we=0, ifid_we=0, idex_bubble=1.
  - Next state is LOAD_STALL.
- LOAD_STALL: RUN defaults apply, because the load is now in MEM and is forwarded. The load-use check is not re-evaluated. Next state is RUN.
- Flag hazard (macro off): id_is_bcond & ex_set_flags → same stall outputs as load-use; next state is FLAG_WAIT. FLAG_WAIT behaves like LOAD_STALL.
- br_taken_ex in RUN, LOAD_STALL or FLAG_WAIT:
  - In the same cycle: ifid_flush=1, idex_bubble=1, pc_we=1, ifid_we=1.
  - If FLUSH_CYCLES>1: enter FLUSH and hold ifid_flush=1 for FLUSH_CYCLES-1 further cycles.
  - If FLUSH_CYCLES=1: stay in RUN.
- br_taken_ex in FLUSH restarts the flush count.
- Priority: FILL > br_taken_ex > load-use > flag. A branch coinciding with a stall condition suppresses the stall; no stall is counted.
- Counters:
  - stall_cnt +1 per cycle in which pc_we=0 outside FILL.
  - flush_cnt +1 per cycle with br_taken_ex.
  - Both saturate at 16'hFFFF.
  - cnt_clr wins over an increment in the same cycle.

## Timing
- Reset values:
  - State FILL, counters 0.
  - pc_we=0, ifid_we=0, ifid_flush=1, idex_bubble=1, flag_fwd=0.
- The first pc_we=1 is exactly FILL_CYCLES rising edges after rst_n deasserts.
- Stall/flush outputs are combinational, with zero latency from the inputs. The state change takes effect at the next edge.
- A load-use stall costs exactly 1 cycle. Back-to-back dependent loads each cost 1 cycle.
- rst_n asserted mid-operation: all outputs immediately take reset values, regardless of clk.
- Counter value is visible the cycle after the event.

## Configuration
- FLAG_FORWARD_EN defined:
  - No flag stall.
  - flag_fwd = id_is_bcond & ex_set_flags in RUN and LOAD_STALL; 0 elsewhere.
  - FLAG_WAIT is unreachable.
- FLAG_FORWARD_EN undefined:
  - flag_fwd is tied 0.
  - B.cond behind a flag setter stalls 1 cycle via FLAG_WAIT.

## Test plan
- Reset release, FILL_CYCLES=4 → pc_we=0 for 4 edges, 1 on the 5th cycle; ifid_flush=1 throughout FILL; stall_cnt stays 0.
- ex_mem_read=1, ex_rd=3, id_rn=3 → pc_we=0, ifid_we=0, idex_bubble=1 for 1 cycle, then RUN; stall_cnt=1. Same case with ex_rd=31 → no stall.
- ex_mem_read=1, ex_rd=5, id_rm=5, id_uses_rm=0 → no stall; with id_uses_rm=1 → 1-cycle stall.
- Load-use hazard and br_taken_ex in the same cycle → ifid_flush=1, idex_bubble=1, pc_we=1; flush_cnt=1, stall_cnt unchanged.
- id_is_bcond=1, ex_set_flags=1:
  - Macro off → 1-cycle stall, flag_fwd=0.
  - Macro on → no stall, flag_fwd=1.
- Preload stall_cnt at 16'hFFFF and force a stall → stays 16'hFFFF. Assert cnt_clr together with a stall → counter reads 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: 5-stage pipeline sequencing (fill, load-use/flag stalls, branch flush, perf counters)
// Ports: clk, rst_n (async, active-low); ID fields id_rn/id_rm/id_rd, id_uses_rm, id_uses_rd, id_is_bcond;
// EX info ex_mem_read, ex_rd, ex_set_flags, br_taken_ex; cnt_clr clears counters.
// Outputs pc_we, ifid_we, ifid_flush, idex_bubble, flag_fwd, stall_cnt, flush_cnt.
// Optional feature macro: FLAG_FORWARD_EN (forward EX flags to B.cond instead of stalling).
module pipeline_hazard_ctrl #(
  parameter int FILL_CYCLES  = 4,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rn,
  input  logic [4:0]  id_rm,
  input  logic [4:0]  id_rd,
  input  logic        id_uses_rm,
  input  logic        id_uses_rd,
  input  logic        id_is_bcond,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  input  logic        ex_set_flags,
  input  logic        br_taken_ex,
  input  logic        cnt_clr,
  output logic        pc_we,
  output logic        ifid_we,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        flag_fwd,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);
  typedef enum logic [2:0] {FILL, RUN, LOAD_STALL, FLAG_WAIT, FLUSH} state_t;
  state_t state, state_nx;
  logic [3:0] fill_cnt;
  logic [1:0] fl_cnt;
  logic load_use, flag_haz;
  assign load_use = ex_mem_read && ex_rd != 5'd31 &&
                    (ex_rd == id_rn || (id_uses_rm && ex_rd == id_rm) || (id_uses_rd && ex_rd == id_rd));
`ifdef FLAG_FORWARD_EN
  assign flag_haz = 1'b0;
`else
  assign flag_haz = id_is_bcond & ex_set_flags;
`endif
  always_comb begin
    state_nx    = state;
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    flag_fwd    = 1'b0;
    case (state)
      FILL: begin
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        state_nx    = fill_cnt <= 4'd1 ? RUN : FILL;
      end
      FLUSH: begin
        ifid_flush  = 1'b1;
        idex_bubble = br_taken_ex;
        state_nx    = (!br_taken_ex && fl_cnt == 2'd1) ? RUN : FLUSH;
      end
      default: begin
        // Only RUN checks hazards: the cycle after a stall the producer is past EX.
        if (br_taken_ex) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          state_nx    = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
        end else if (state == RUN && (load_use || flag_haz)) begin
          pc_we       = 1'b0;
          ifid_we     = 1'b0;
          idex_bubble = 1'b1;
          state_nx    = load_use ? LOAD_STALL : FLAG_WAIT;
        end else
          state_nx = RUN;
      end
    endcase
`ifdef FLAG_FORWARD_EN
    flag_fwd = (state == RUN || state == LOAD_STALL) && id_is_bcond && ex_set_flags;
`endif
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= FILL;
      fill_cnt  <= 4'(FILL_CYCLES);
      fl_cnt    <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state     <= state_nx;
      fill_cnt  <= state == FILL ? fill_cnt - 4'd1 : fill_cnt;
      fl_cnt    <= (br_taken_ex && state != FILL) ? 2'(FLUSH_CYCLES - 1) : state == FLUSH ? fl_cnt - 2'd1 : fl_cnt;
      stall_cnt <= cnt_clr ? '0 : (!pc_we && state != FILL && stall_cnt != 16'hFFFF) ? stall_cnt + 16'd1 : stall_cnt;
      flush_cnt <= cnt_clr ? '0 : (br_taken_ex && flush_cnt != 16'hFFFF) ? flush_cnt + 16'd1 : flush_cnt;
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: randomized + directed check of pipeline_hazard_ctrl against a cycle-level model
module tb_pipeline_hazard_ctrl;
  localparam int FILL = 4, FLUSHC = 1;
  logic clk = 0, rst_n = 0;
  logic [4:0] id_rn, id_rm, id_rd, ex_rd;
  logic id_uses_rm, id_uses_rd, id_is_bcond, ex_mem_read, ex_set_flags, br_taken_ex, cnt_clr;
  logic pc_we, ifid_we, ifid_flush, idex_bubble, flag_fwd;
  logic [15:0] stall_cnt, flush_cnt;
  int n_vec = 0, n_bad = 0;
  int m_fill, m_flush, m_stall, m_flushc;
  bit m_shadow;
  logic [4:0] regs [4] = '{5'd3, 5'd5, 5'd7, 5'd31};
  always #5 clk = ~clk;
  pipeline_hazard_ctrl #(.FILL_CYCLES(FILL), .FLUSH_CYCLES(FLUSHC)) dut (
    .clk(clk), .rst_n(rst_n), .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
    .id_uses_rm(id_uses_rm), .id_uses_rd(id_uses_rd), .id_is_bcond(id_is_bcond),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_set_flags(ex_set_flags),
    .br_taken_ex(br_taken_ex), .cnt_clr(cnt_clr), .pc_we(pc_we), .ifid_we(ifid_we),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .flag_fwd(flag_fwd),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic idle();
    {id_rn, id_rm, id_rd, ex_rd} = '0;
    {id_uses_rm, id_uses_rd, id_is_bcond, ex_mem_read, ex_set_flags, br_taken_ex, cnt_clr} = '0;
  endtask
  task automatic model_reset();
    m_fill = FILL; m_flush = 0; m_stall = 0; m_flushc = 0; m_shadow = 0;
  endtask
  // One cycle: inputs already driven just after a negedge; compare, take the edge, advance the model.
  task automatic cycle();
    bit lu, fh, stall;
    bit e_pc, e_we, e_fl, e_bub, e_ff;
    #1;
    lu = ex_mem_read && ex_rd != 31 &&
         (ex_rd == id_rn || (id_uses_rm && ex_rd == id_rm) || (id_uses_rd && ex_rd == id_rd));
`ifdef FLAG_FORWARD_EN
    fh = 0;
    e_ff = m_fill == 0 && m_flush == 0 && id_is_bcond && ex_set_flags;
`else
    fh = id_is_bcond && ex_set_flags;
    e_ff = 0;
`endif
    stall = 0;
    if (m_fill > 0)                  {e_pc, e_we, e_fl, e_bub} = 4'b0011;
    else if (br_taken_ex)            {e_pc, e_we, e_fl, e_bub} = 4'b1111;
    else if (m_flush > 0)            {e_pc, e_we, e_fl, e_bub} = 4'b1110;
    else if (!m_shadow && (lu || fh)) begin
      {e_pc, e_we, e_fl, e_bub} = 4'b0001;
      stall = 1;
    end else                         {e_pc, e_we, e_fl, e_bub} = 4'b1100;
    chk("pc_we", pc_we, e_pc);
    chk("ifid_we", ifid_we, e_we);
    chk("ifid_flush", ifid_flush, e_fl);
    chk("idex_bubble", idex_bubble, e_bub);
    chk("flag_fwd", flag_fwd, e_ff);
    chk("stall_cnt", stall_cnt, m_stall);
    chk("flush_cnt", flush_cnt, m_flushc);
    @(posedge clk);
    m_stall  = cnt_clr ? 0 : (stall && m_stall < 65535) ? m_stall + 1 : m_stall;
    m_flushc = cnt_clr ? 0 : (br_taken_ex && m_flushc < 65535) ? m_flushc + 1 : m_flushc;
    m_flush  = (m_fill == 0 && br_taken_ex) ? FLUSHC - 1 : (m_flush > 0 ? m_flush - 1 : 0);
    m_shadow = stall;
    m_fill   = m_fill > 0 ? m_fill - 1 : 0;
    @(negedge clk);
  endtask
  initial begin
    idle();
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_pc_we", pc_we, 0);
    chk("rst_ifid_we", ifid_we, 0);
    chk("rst_ifid_flush", ifid_flush, 1);
    chk("rst_idex_bubble", idex_bubble, 1);
    chk("rst_flag_fwd", flag_fwd, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    @(negedge clk);
    rst_n = 1;
    repeat (FILL) cycle();
    #1 chk("pc_we_after_fill", pc_we, 1);
    chk("stall_cnt_after_fill", stall_cnt, 0);
    ex_mem_read = 1; ex_rd = 3; id_rn = 3;
    cycle();
    cycle();
    idle(); cycle();
    chk("loaduse_stall_cnt", stall_cnt, 1);
    ex_mem_read = 1; ex_rd = 31; id_rn = 31; cycle();
    idle(); ex_mem_read = 1; ex_rd = 5; id_rm = 5; id_rn = 1; cycle();
    id_uses_rm = 1; cycle(); cycle();
    idle(); cycle();
    ex_mem_read = 1; ex_rd = 7; id_rd = 7; id_rn = 2; id_uses_rd = 1; cycle(); cycle();
    idle(); cycle();
    ex_mem_read = 1; ex_rd = 3; id_rn = 3; br_taken_ex = 1; cycle();
    idle(); cycle();
    chk("br_flush_cnt", flush_cnt, 1);
    chk("br_stall_cnt", stall_cnt, 3);
    id_is_bcond = 1; ex_set_flags = 1; cycle(); cycle();
    idle(); cycle();
    repeat (3000) begin
      id_rn = regs[$urandom_range(0, 3)];
      id_rm = regs[$urandom_range(0, 3)];
      id_rd = regs[$urandom_range(0, 3)];
      ex_rd = regs[$urandom_range(0, 3)];
      id_uses_rm   = 1'($urandom_range(0, 1));
      id_uses_rd   = 1'($urandom_range(0, 1));
      id_is_bcond  = $urandom_range(0, 3) == 0;
      ex_set_flags = 1'($urandom_range(0, 1));
      ex_mem_read  = 1'($urandom_range(0, 1));
      br_taken_ex  = $urandom_range(0, 7) == 0;
      cnt_clr      = $urandom_range(0, 63) == 0;
      cycle();
    end
    ex_mem_read = 1; ex_rd = 3; id_rn = 3; br_taken_ex = 0; cnt_clr = 0;
    #2 rst_n = 0;
    #1;
    chk("async_pc_we", pc_we, 0);
    chk("async_ifid_flush", ifid_flush, 1);
    chk("async_idex_bubble", idex_bubble, 1);
    chk("async_stall_cnt", stall_cnt, 0);
    chk("async_flush_cnt", flush_cnt, 0);
    idle();
    model_reset();
    @(negedge clk);
    rst_n = 1;
    repeat (FILL + 1) cycle();
    force dut.stall_cnt = 16'hFFFF;
    #1 release dut.stall_cnt;
    m_stall = 65535;
    ex_mem_read = 1; ex_rd = 5; id_rn = 5; cycle();
    idle(); cycle();
    chk("sat_stall_cnt", stall_cnt, 16'hFFFF);
    ex_mem_read = 1; ex_rd = 5; id_rn = 5; cnt_clr = 1; cycle();
    idle(); cycle();
    chk("clr_stall_cnt", stall_cnt, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
